// File: rtl/mdu_pkg.sv
// Shared definitions for the EX-stage multiply/divide unit: op codes,
// FSM state encoding, datapath mode and the operand magnitude helper.
package mdu_pkg;

  // Operation codes driven by ID/EX on op_i. Code 7 is unused and acts as NONE.
  localparam logic [2:0] OP_NONE  = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  // Widest datapath the helper function supports.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DIV0 = 2'd2,
    FIN  = 2'd3
  } state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } mode_t;

  // Magnitude of a w-bit value held zero-extended in x. When signed_flag is
  // set and bit w-1 is 1, the two's complement negation is returned; only the
  // low w bits of the result are meaningful.
  function automatic logic [MAX_W-1:0] abs_w(input logic [MAX_W-1:0] x,
                                             input logic             signed_flag,
                                             input int               w);
    if (signed_flag && x[w-1]) begin
      return -x;
    end
    return x;
  endfunction

endpackage

// File: rtl/mdu_shift_core.sv
// Iterative datapath shared by multiply and divide: a {acc, q} register pair
// plus the operand register m. Multiply runs LSB-first shift-add; divide runs
// MSB-first restoring shift-subtract. After DATA_W steps acc holds the upper
// product half / remainder and q the lower product half / quotient.
module mdu_shift_core
  import mdu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  mode_t             mode,
  input  logic [DATA_W-1:0] opa,
  input  logic [DATA_W-1:0] opb,
  output logic [DATA_W-1:0] hi_raw,
  output logic [DATA_W-1:0] lo_raw
);

  logic [DATA_W-1:0] acc;
  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] m;
  logic [DATA_W:0]   sum;
  logic [DATA_W:0]   rem;
  logic [DATA_W:0]   diff;

  // One-step arithmetic for both modes; the carry/borrow bit is kept.
  always_comb begin
    sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    rem  = {acc, q[DATA_W-1]};
    diff = rem - {1'b0, m};
  end

  // Load operands, then advance one multiply or divide step per enabled cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
      q   <= '0;
      m   <= '0;
    end else if (load) begin
      acc <= '0;
      q   <= opa;
      m   <= opb;
    end else if (step) begin
      if (mode == MODE_MUL) begin
        acc <= sum[DATA_W:1];
        q   <= {sum[0], q[DATA_W-1:1]};
      end else if (!diff[DATA_W]) begin
        // Partial remainder >= divisor: keep the difference, quotient bit 1.
        acc <= diff[DATA_W-1:0];
        q   <= {q[DATA_W-2:0], 1'b1};
      end else begin
        // Borrow: restore the shifted remainder, quotient bit 0.
        acc <= rem[DATA_W-1:0];
        q   <= {q[DATA_W-2:0], 1'b0};
      end
    end
  end

  assign hi_raw = acc;
  assign lo_raw = q;

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle multiply/divide unit owning the architectural HI/LO
// registers. Holds the pipeline via stall_o while an iterative operation runs.
module ex_muldiv
  import mdu_pkg::*;
#(
  parameter int DATA_W = 32,                 // must be even and >= 4
  parameter int CNT_W  = $clog2(DATA_W) + 1  // derived, leave at default
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [2:0]        op_i,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic              annul_i,
  output logic              stall_o,
  output logic              done_o,
  output logic              div0_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;
  logic              done_q;
  logic              div0_q;
  logic              is_div_r;
  logic              neg_q;   // negate product / quotient in FIN
  logic              neg_r;   // negate remainder in FIN

  logic              accept;
  logic              is_mul;
  logic              is_div;
  logic              sgn_op;
  logic              div_by0;
  logic              load;
  logic [DATA_W-1:0] a_mag;
  logic [DATA_W-1:0] b_mag;
  logic [DATA_W-1:0] hi_raw;
  logic [DATA_W-1:0] lo_raw;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0] hi_fix;
  logic [DATA_W-1:0] lo_fix;

  // Decode the incoming request; only meaningful while IDLE.
  always_comb begin
    // NOTE: every signal assigned here gets a value on every path, otherwise synthesis infers a latch.
    accept  = !rst && (state == IDLE) && start_i && !annul_i;
    is_mul  = (op_i == OP_MULT) || (op_i == OP_MULTU);
    is_div  = (op_i == OP_DIV)  || (op_i == OP_DIVU);
    sgn_op  = (op_i == OP_MULT) || (op_i == OP_DIV);
    div_by0 = is_div && (b_i == '0);
    load    = accept && (is_mul || (is_div && !div_by0));
    a_mag   = DATA_W'(abs_w(MAX_W'(a_i), sgn_op, DATA_W));
    b_mag   = DATA_W'(abs_w(MAX_W'(b_i), sgn_op, DATA_W));
  end

  mdu_shift_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .step   (state == RUN),
    .mode   (is_div_r ? MODE_DIV : MODE_MUL),
    .opa    (a_mag),
    .opb    (b_mag),
    .hi_raw (hi_raw),
    .lo_raw (lo_raw)
  );

  // Sign fix-up of the unsigned core result, consumed in the FIN cycle.
  always_comb begin
    prod     = {hi_raw, lo_raw};
    prod_fix = neg_q ? -prod : prod;
    if (is_div_r) begin
      lo_fix = neg_q ? -lo_raw : lo_raw;
      hi_fix = neg_r ? -hi_raw : hi_raw;
    end else begin
      hi_fix = prod_fix[2*DATA_W-1:DATA_W];
      lo_fix = prod_fix[DATA_W-1:0];
    end
  end

  // Control FSM, iteration counter, HI/LO and the registered status pulses.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      hi       <= '0;
      lo       <= '0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
      is_div_r <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      div0_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (op_i == OP_MTHI) begin
              hi <= a_i;
            end else if (op_i == OP_MTLO) begin
              lo <= a_i;
            end else if (load) begin
              is_div_r <= is_div;
              neg_q    <= sgn_op && (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
              neg_r    <= sgn_op && is_div && a_i[DATA_W-1];
              cnt      <= '0;
              state    <= RUN;
            end else if (div_by0) begin
              done_q <= 1'b1;
              div0_q <= 1'b1;
              state  <= DIV0;
            end
          end
        end
        RUN: begin
          if (annul_i) begin
            state <= IDLE;
          end else if (cnt == LAST_STEP) begin
            done_q <= 1'b1;
            state  <= FIN;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DIV0: begin
          state <= IDLE;
        end
        FIN: begin
          if (!annul_i) begin
            hi <= hi_fix;
            lo <= lo_fix;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A flush in DIV0/FIN suppresses the already-registered pulses.
  assign done_o  = done_q && !annul_i;
  assign div0_o  = div0_q && !annul_i;
  assign stall_o = (accept && (is_mul || is_div)) || (state != IDLE);
  assign hi_o    = hi;
  assign lo_o    = lo;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed cases plus randomized operations
// at DATA_W=32 and DATA_W=16, checked against an arithmetic reference model.
module tb_ex_muldiv;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start32, start16, annul;
  logic [2:0]  op;
  logic [31:0] a, b;

  logic        stall32, done32, div032;
  logic [31:0] hi32, lo32;
  logic        stall16, done16, div016;
  logic [15:0] hi16, lo16;

  int checks   = 0;
  int failures = 0;

  // Model HI/LO per instance: index 0 = 32-bit, 1 = 16-bit.
  logic [63:0] mhi [2];
  logic [63:0] mlo [2];

  always #5 clk = ~clk;

  ex_muldiv #(.DATA_W(32)) dut32 (
    .clk(clk), .rst(rst), .start_i(start32), .op_i(op), .a_i(a), .b_i(b),
    .annul_i(annul), .stall_o(stall32), .done_o(done32), .div0_o(div032),
    .hi_o(hi32), .lo_o(lo32)
  );

  ex_muldiv #(.DATA_W(16)) dut16 (
    .clk(clk), .rst(rst), .start_i(start16), .op_i(op), .a_i(a[15:0]), .b_i(b[15:0]),
    .annul_i(annul), .stall_o(stall16), .done_o(done16), .div0_o(div016),
    .hi_o(hi16), .lo_o(lo16)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int width_of(input int k);
    return (k == 0) ? 32 : 16;
  endfunction

  function automatic logic [63:0] get_hi(input int k);
    return (k == 0) ? 64'(hi32) : 64'(hi16);
  endfunction

  function automatic logic [63:0] get_lo(input int k);
    return (k == 0) ? 64'(lo32) : 64'(lo16);
  endfunction

  function automatic logic get_stall(input int k);
    return (k == 0) ? stall32 : stall16;
  endfunction

  function automatic logic get_done(input int k);
    return (k == 0) ? done32 : done16;
  endfunction

  function automatic logic get_div0(input int k);
    return (k == 0) ? div032 : div016;
  endfunction

  // Architectural behaviour from plain integer arithmetic.
  task automatic model(input int w, input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                       inout logic [63:0] h, inout logic [63:0] l, output bit dz, output bit busy);
    logic [63:0] mask, ux, uy, up;
    longint sx, sy, p, r;
    mask = (64'd1 << w) - 64'd1;
    ux = x & mask;
    uy = y & mask;
    sx = ux[w-1] ? longint'(ux) - (longint'(1) << w) : longint'(ux);
    sy = uy[w-1] ? longint'(uy) - (longint'(1) << w) : longint'(uy);
    dz   = 1'b0;
    busy = 1'b0;
    case (o)
      OP_MULTU: begin busy = 1'b1; up = ux * uy; h = (up >> w) & mask; l = up & mask; end
      OP_MULT:  begin busy = 1'b1; p = sx * sy; h = 64'(p >>> w) & mask; l = 64'(p) & mask; end
      OP_DIVU:  if (uy == 0) dz = 1'b1;
                else begin busy = 1'b1; l = ux / uy; h = ux % uy; end
      OP_DIV:   if (uy == 0) dz = 1'b1;
                else begin busy = 1'b1; p = sx / sy; r = sx % sy; l = 64'(p) & mask; h = 64'(r) & mask; end
      OP_MTHI:  h = ux;
      OP_MTLO:  l = ux;
      default:  ;
    endcase
  endtask

  // Issue one operation on instance k (called in the low clock phase) and check
  // stall length, pulses and the resulting HI/LO.
  task automatic run_op(input int k, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int stalls = 0, dones = 0, div0s = 0, exp_stall;
    bit dz, busy;
    op = o; a = x; b = y;
    if (k == 0) start32 = 1'b1; else start16 = 1'b1;
    #1;
    while (get_stall(k) && stalls < 200) begin
      stalls++;
      dones += int'(get_done(k));
      div0s += int'(get_div0(k));
      @(posedge clk);
      @(negedge clk);
      start32 = 1'b0; start16 = 1'b0;
      op = 3'($urandom); a = $urandom; b = $urandom;
      #1;
    end
    if (stalls == 0) begin
      @(posedge clk);
      @(negedge clk);
      start32 = 1'b0; start16 = 1'b0;
      #1;
    end
    model(width_of(k), o, 64'(x), 64'(y), mhi[k], mlo[k], dz, busy);
    exp_stall = busy ? width_of(k) + 2 : (dz ? 2 : 0);
    check($sformatf("stall_len w%0d op%0d", width_of(k), o), 64'(stalls), 64'(exp_stall));
    check($sformatf("done_cnt w%0d op%0d", width_of(k), o), 64'(dones), 64'((busy || dz) ? 1 : 0));
    check($sformatf("div0_cnt w%0d op%0d", width_of(k), o), 64'(div0s), 64'(dz ? 1 : 0));
    check($sformatf("hi w%0d op%0d a=%0h b=%0h", width_of(k), o, x, y), get_hi(k), mhi[k]);
    check($sformatf("lo w%0d op%0d a=%0h b=%0h", width_of(k), o, x, y), get_lo(k), mlo[k]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] x, y;
    rst = 1'b1; start32 = 1'b0; start16 = 1'b0; annul = 1'b0; op = OP_NONE; a = '0; b = '0;
    for (int k = 0; k < 2; k++) begin mhi[k] = '0; mlo[k] = '0; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset hi32", 64'(hi32), 64'd0);
    check("reset lo32", 64'(lo32), 64'd0);
    check("reset stall32", 64'(stall32), 64'd0);
    check("reset done32", 64'(done32), 64'd0);
    check("reset div0_32", 64'(div032), 64'd0);
    check("reset hi16", 64'(hi16), 64'd0);

    // Directed cases at 32 bits.
    run_op(0, OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu hi const", 64'(hi32), 64'hFFFF_FFFE);
    check("multu lo const", 64'(lo32), 64'h0000_0001);
    run_op(0, OP_MULT, 32'hFFFF_FFF9, 32'd3);
    check("mult -7*3 lo const", 64'(lo32), 64'hFFFF_FFEB);
    run_op(0, OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div -7/2 lo const", 64'(lo32), 64'hFFFF_FFFD);
    check("div -7/2 hi const", 64'(hi32), 64'hFFFF_FFFF);
    run_op(0, OP_DIVU, 32'd100, 32'd7);
    check("divu 100/7 lo const", 64'(lo32), 64'd14);
    check("divu 100/7 hi const", 64'(hi32), 64'd2);
    run_op(0, OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div min/-1 lo const", 64'(lo32), 64'h8000_0000);
    check("div min/-1 hi const", 64'(hi32), 64'd0);
    run_op(0, OP_MULT, 32'h1357_9BDF, 32'h0246_8ACE);
    run_op(0, OP_DIV, 32'h1234_5678, 32'd0);
    run_op(0, OP_DIVU, 32'hDEAD_BEEF, 32'd0);
    run_op(0, OP_MTHI, 32'h1234, 32'd0);
    run_op(0, OP_MTLO, 32'h5678, 32'd0);
    check("mthi const", 64'(hi32), 64'h1234);
    check("mtlo const", 64'(lo32), 64'h5678);

    // Flush in IDLE drops an MT op.
    op = OP_MTHI; a = 32'hCAFE_F00D; start32 = 1'b1; annul = 1'b1;
    #1;
    check("annul idle stall", 64'(stall32), 64'd0);
    @(posedge clk);
    @(negedge clk);
    start32 = 1'b0; annul = 1'b0;
    #1;
    check("annul idle hi kept", 64'(hi32), mhi[0]);

    // Flush at RUN cycle 10 of a multiply.
    op = OP_MULTU; a = 32'h0001_0001; b = 32'h0000_0100; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    annul = 1'b1;
    #1;
    check("annul run stall", 64'(stall32), 64'd1);
    check("annul run done", 64'(done32), 64'd0);
    @(posedge clk);
    @(negedge clk);
    annul = 1'b0;
    #1;
    check("annul next stall", 64'(stall32), 64'd0);
    check("annul next done", 64'(done32), 64'd0);
    check("annul hi kept", 64'(hi32), mhi[0]);
    check("annul lo kept", 64'(lo32), mlo[0]);
    run_op(0, OP_DIVU, 32'd1000, 32'd33);

    // Reset in the middle of RUN.
    op = OP_MULT; a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; start32 = 1'b1;
    @(posedge clk);
    #1 start32 = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst mid-run hi32", 64'(hi32), 64'd0);
    check("rst mid-run lo32", 64'(lo32), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst mid-run stall32", 64'(stall32), 64'd0);
    for (int k = 0; k < 2; k++) begin mhi[k] = '0; mlo[k] = '0; end

    // Directed cases at 16 bits.
    run_op(1, OP_MULTU, 32'h0000_FFFF, 32'h0000_FFFF);
    check("multu16 hi const", 64'(hi16), 64'hFFFE);
    check("multu16 lo const", 64'(lo16), 64'h0001);
    run_op(1, OP_DIVU, 32'd100, 32'd7);
    check("divu16 lo const", 64'(lo16), 64'd14);
    check("divu16 hi const", 64'(hi16), 64'd2);
    run_op(1, OP_DIV, 32'h0000_8000, 32'h0000_FFFF);

    // Randomized operations on both widths, including zero, -1 and MIN operands.
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 40; i++) begin
        x = $urandom;
        y = $urandom;
        case ($urandom_range(0, 9))
          0: y = '0;
          1: y = '1;
          2: x = (k == 0) ? 32'h8000_0000 : 32'h0000_8000;
          3: begin x = (k == 0) ? 32'h8000_0000 : 32'h0000_8000; y = '1; end
          4: y = 32'($urandom_range(1, 9));
          default: ;
        endcase
        run_op(k, 3'($urandom_range(0, 7)), x, y);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
